// File: rtl/alu_rs_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_rs_pkg : shared ALU opcodes, flag positions, RS size defaults  |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
package alu_rs_pkg;

   localparam int DEPTH_DEF = 4;
   localparam int TAG_W_DEF = 4;

   localparam logic [3:0] ALU_ADDU = 4'b0000;
   localparam logic [3:0] ALU_SUBU = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0011;
   localparam logic [3:0] ALU_AND  = 4'b0100;
   localparam logic [3:0] ALU_OR   = 4'b0101;
   localparam logic [3:0] ALU_XOR  = 4'b0110;
   localparam logic [3:0] ALU_NOR  = 4'b0111;
   localparam logic [3:0] ALU_LUI  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1010;
   localparam logic [3:0] ALU_SLT  = 4'b1011;
   localparam logic [3:0] ALU_SRA  = 4'b1100;
   localparam logic [3:0] ALU_SRL  = 4'b1101;
   localparam logic [3:0] ALU_SLL  = 4'b1110;

   // out_flags = {zr, cy, ng, of}
   localparam int FLAG_ZR = 3;
   localparam int FLAG_CY = 2;
   localparam int FLAG_NG = 1;
   localparam int FLAG_OF = 0;

endpackage
`default_nettype wire

// File: rtl/alu_rs_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_rs_if : issue, CDB, ALU and broadcast signals of the ALU RS    |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
interface alu_rs_if #(
   parameter int TAG_W = alu_rs_pkg::TAG_W_DEF
);
   logic             issue_valid;
   logic             issue_ready;
   logic [3:0]       issue_aluc;
   logic             issue_s1_rdy;
   logic             issue_s2_rdy;
   logic [31:0]      issue_s1_val;
   logic [31:0]      issue_s2_val;
   logic [TAG_W-1:0] issue_s1_tag;
   logic [TAG_W-1:0] issue_s2_tag;
   logic [TAG_W-1:0] issue_dst_tag;
   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [31:0]      cdb_data;
   logic [3:0]       alu_aluc;
   logic [31:0]      alu_src1;
   logic [31:0]      alu_src2;
   logic [31:0]      alu_result;
   logic             alu_zr;
   logic             alu_cy;
   logic             alu_ng;
   logic             alu_of;
   logic             out_valid;
   logic             out_ready;
   logic [TAG_W-1:0] out_tag;
   logic [31:0]      out_data;
   logic [3:0]       out_flags;

   // slave: the reservation station side
   modport slave (
      input  issue_valid, issue_aluc, issue_s1_rdy, issue_s2_rdy, issue_s1_val,
             issue_s2_val, issue_s1_tag, issue_s2_tag, issue_dst_tag,
             cdb_valid, cdb_tag, cdb_data,
             alu_result, alu_zr, alu_cy, alu_ng, alu_of, out_ready,
      output issue_ready, alu_aluc, alu_src1, alu_src2,
             out_valid, out_tag, out_data, out_flags
   );

   modport master (
      output issue_valid, issue_aluc, issue_s1_rdy, issue_s2_rdy, issue_s1_val,
             issue_s2_val, issue_s1_tag, issue_s2_tag, issue_dst_tag,
             cdb_valid, cdb_tag, cdb_data,
             alu_result, alu_zr, alu_cy, alu_ng, alu_of, out_ready,
      input  issue_ready, alu_aluc, alu_src1, alu_src2,
             out_valid, out_tag, out_data, out_flags
   );
endinterface
`default_nettype wire

// File: rtl/alu_rs_entry.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rs_entry : one station slot with issue-time capture and CDB wakeup |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module rs_entry
   import alu_rs_pkg::*;
#(
   parameter int TAG_W = TAG_W_DEF
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             flush,
   input  wire logic             alloc,
   input  wire logic             clear,
   input  wire logic [3:0]       in_aluc,
   input  wire logic             in_s1_rdy,
   input  wire logic [31:0]      in_s1_val,
   input  wire logic [TAG_W-1:0] in_s1_tag,
   input  wire logic             in_s2_rdy,
   input  wire logic [31:0]      in_s2_val,
   input  wire logic [TAG_W-1:0] in_s2_tag,
   input  wire logic [TAG_W-1:0] in_dst_tag,
   input  wire logic             cdb_valid,
   input  wire logic [TAG_W-1:0] cdb_tag,
   input  wire logic [31:0]      cdb_data,
   output logic                  busy,
   output logic                  ready,
   output logic [3:0]            aluc,
   output logic [31:0]           src1,
   output logic [31:0]           src2,
   output logic [TAG_W-1:0]      dst_tag
);
   logic             r_busy;
   logic [3:0]       r_aluc;
   logic             r_s1_rdy, r_s2_rdy;
   logic [31:0]      r_s1_val, r_s2_val;
   logic [TAG_W-1:0] r_s1_tag, r_s2_tag, r_dst;
   logic             w_new1_hit, w_new2_hit, w_wake1, w_wake2;

   // A producer broadcasting on the issue edge must be caught here or the op never wakes
   assign w_new1_hit = cdb_valid && (cdb_tag == in_s1_tag);
   assign w_new2_hit = cdb_valid && (cdb_tag == in_s2_tag);
   assign w_wake1    = cdb_valid && r_busy && !r_s1_rdy && (cdb_tag == r_s1_tag);
   assign w_wake2    = cdb_valid && r_busy && !r_s2_rdy && (cdb_tag == r_s2_tag);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy   <= 1'b0;
         r_aluc   <= '0;
         r_s1_rdy <= 1'b0;
         r_s2_rdy <= 1'b0;
         r_s1_val <= '0;
         r_s2_val <= '0;
         r_s1_tag <= '0;
         r_s2_tag <= '0;
         r_dst    <= '0;
      end else if (flush) begin
         r_busy <= 1'b0;
      end else if (alloc) begin
         r_busy   <= 1'b1;
         r_aluc   <= in_aluc;
         r_dst    <= in_dst_tag;
         r_s1_tag <= in_s1_tag;
         r_s2_tag <= in_s2_tag;
         r_s1_rdy <= in_s1_rdy || w_new1_hit;
         r_s2_rdy <= in_s2_rdy || w_new2_hit;
         r_s1_val <= in_s1_rdy ? in_s1_val : cdb_data;
         r_s2_val <= in_s2_rdy ? in_s2_val : cdb_data;
      end else begin
         if (clear) begin
            r_busy <= 1'b0;
         end
         if (w_wake1) begin
            r_s1_rdy <= 1'b1;
            r_s1_val <= cdb_data;
         end
         if (w_wake2) begin
            r_s2_rdy <= 1'b1;
            r_s2_val <= cdb_data;
         end
      end
   end

   assign busy    = r_busy;
   assign ready   = r_busy && r_s1_rdy && r_s2_rdy;
   assign aluc    = r_aluc;
   assign src1    = r_s1_val;
   assign src2    = r_s2_val;
   assign dst_tag = r_dst;

endmodule
`default_nettype wire

// File: rtl/alu_rs.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_rs   : ALU reservation station with select and result register |
// |            optional flag storage under macro ALU_RS_FLAGS_EN       |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module alu_rs
   import alu_rs_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int TAG_W = TAG_W_DEF
) (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic flush,
   alu_rs_if.slave   bus
);
   logic [DEPTH-1:0] w_busy, w_ready, w_free, w_alloc, w_cand, w_sel;
   logic [3:0]       w_aluc [DEPTH];
   logic [31:0]      w_src1 [DEPTH];
   logic [31:0]      w_src2 [DEPTH];
   logic [TAG_W-1:0] w_dst  [DEPTH];
   logic [3:0]       w_mux_aluc;
   logic [31:0]      w_mux_src1, w_mux_src2;
   logic [TAG_W-1:0] w_mux_dst;
   logic             w_can_take, w_dispatch;
   logic             r_valid;
   logic [TAG_W-1:0] r_tag;
   logic [31:0]      r_data;

   // Occupancy is taken from registers only, so a slot freed by dispatch waits a cycle
   assign w_free     = ~w_busy;
   assign w_alloc    = bus.issue_valid ? (w_free & (~w_free + DEPTH'(1))) : '0;
   assign w_can_take = !r_valid || bus.out_ready;
   assign w_cand     = w_ready & {DEPTH{w_can_take}};
   assign w_sel      = w_cand & (~w_cand + DEPTH'(1));
   assign w_dispatch = (|w_cand) && !flush;

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_entry
         rs_entry #(.TAG_W(TAG_W)) u_entry (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (flush),
            .alloc      (w_alloc[i]),
            .clear      (w_sel[i]),
            .in_aluc    (bus.issue_aluc),
            .in_s1_rdy  (bus.issue_s1_rdy),
            .in_s1_val  (bus.issue_s1_val),
            .in_s1_tag  (bus.issue_s1_tag),
            .in_s2_rdy  (bus.issue_s2_rdy),
            .in_s2_val  (bus.issue_s2_val),
            .in_s2_tag  (bus.issue_s2_tag),
            .in_dst_tag (bus.issue_dst_tag),
            .cdb_valid  (bus.cdb_valid),
            .cdb_tag    (bus.cdb_tag),
            .cdb_data   (bus.cdb_data),
            .busy       (w_busy[i]),
            .ready      (w_ready[i]),
            .aluc       (w_aluc[i]),
            .src1       (w_src1[i]),
            .src2       (w_src2[i]),
            .dst_tag    (w_dst[i])
         );
      end
   endgenerate

   always_comb begin
      w_mux_aluc = '0;
      w_mux_src1 = '0;
      w_mux_src2 = '0;
      w_mux_dst  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_sel[i]) begin
            w_mux_aluc = w_aluc[i];
            w_mux_src1 = w_src1[i];
            w_mux_src2 = w_src2[i];
            w_mux_dst  = w_dst[i];
         end
      end
   end

   assign bus.issue_ready = |w_free;
   assign bus.alu_aluc    = w_mux_aluc;
   assign bus.alu_src1    = w_mux_src1;
   assign bus.alu_src2    = w_mux_src2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_tag   <= '0;
         r_data  <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_dispatch) begin
         r_valid <= 1'b1;
         r_tag   <= w_mux_dst;
         r_data  <= bus.alu_result;
      end else if (bus.out_ready) begin
         r_valid <= 1'b0;
      end
   end

`ifdef ALU_RS_FLAGS_EN
   logic [3:0] r_flags;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flags <= '0;
      end else if (w_dispatch) begin
         r_flags[FLAG_ZR] <= bus.alu_zr;
         r_flags[FLAG_CY] <= bus.alu_cy;
         r_flags[FLAG_NG] <= bus.alu_ng;
         r_flags[FLAG_OF] <= bus.alu_of;
      end
   end

   assign bus.out_flags = r_flags;
`else
   logic w_unused_flags;
   assign w_unused_flags = ^{bus.alu_zr, bus.alu_cy, bus.alu_ng, bus.alu_of};
   assign bus.out_flags  = 4'b0000;
`endif

   assign bus.out_valid = r_valid;
   assign bus.out_tag   = r_tag;
   assign bus.out_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_alu_rs.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alu_rs : directed bench with ALU model and result scoreboard    |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
module tb_alu_rs;
   import alu_rs_pkg::*;

   localparam int DEPTH = 4;
   localparam int TAG_W = 4;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [31:0]      data;
      logic [3:0]       flags;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   int   n_pass = 0;
   int   n_total = 0;
   int   n_fail = 0;
   exp_t sb[$];
   exp_t mon_e;
   exp_t ops4[5];

   always #5 clk = ~clk;

   alu_rs_if #(.TAG_W(TAG_W)) bus ();

   alu_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   // Combinational ALU attached to the station's alu_* ports
   logic [32:0] m_sum, m_dif;
   logic [31:0] m_res;
   logic        m_cy, m_of;
   always_comb begin
      m_sum = {1'b0, bus.alu_src1} + {1'b0, bus.alu_src2};
      m_dif = {1'b0, bus.alu_src1} - {1'b0, bus.alu_src2};
      m_res = '0;
      m_cy  = 1'b0;
      m_of  = 1'b0;
      case (bus.alu_aluc)
         ALU_ADDU, ALU_ADD: begin
            m_res = m_sum[31:0];
            m_cy  = m_sum[32];
            m_of  = (bus.alu_src1[31] == bus.alu_src2[31]) && (m_sum[31] != bus.alu_src1[31]);
         end
         ALU_SUBU, ALU_SUB: begin
            m_res = m_dif[31:0];
            m_cy  = m_dif[32];
            m_of  = (bus.alu_src1[31] != bus.alu_src2[31]) && (m_dif[31] != bus.alu_src1[31]);
         end
         ALU_AND:  m_res = bus.alu_src1 & bus.alu_src2;
         ALU_OR:   m_res = bus.alu_src1 | bus.alu_src2;
         ALU_XOR:  m_res = bus.alu_src1 ^ bus.alu_src2;
         ALU_NOR:  m_res = ~(bus.alu_src1 | bus.alu_src2);
         ALU_LUI:  m_res = {bus.alu_src2[15:0], 16'h0000};
         ALU_SLTU: m_res = {31'd0, bus.alu_src1 < bus.alu_src2};
         ALU_SLT:  m_res = {31'd0, $signed(bus.alu_src1) < $signed(bus.alu_src2)};
         ALU_SRA:  m_res = $signed(bus.alu_src2) >>> bus.alu_src1[4:0];
         ALU_SRL:  m_res = bus.alu_src2 >> bus.alu_src1[4:0];
         ALU_SLL:  m_res = bus.alu_src2 << bus.alu_src1[4:0];
         default:  m_res = '0;
      endcase
      bus.alu_result = m_res;
      bus.alu_zr     = (m_res == 32'd0);
      bus.alu_cy     = m_cy;
      bus.alu_ng     = m_res[31];
      bus.alu_of     = m_of;
   end

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   function automatic logic [3:0] fexp(input logic [3:0] f);
`ifdef ALU_RS_FLAGS_EN
      return f;
`else
      return 4'b0000;
`endif
   endfunction

   task automatic issue_op(input logic [3:0] op, input logic s1r, input logic [31:0] s1v,
                           input logic [TAG_W-1:0] s1t, input logic s2r, input logic [31:0] s2v,
                           input logic [TAG_W-1:0] dst);
      bus.issue_valid   = 1'b1;
      bus.issue_aluc    = op;
      bus.issue_s1_rdy  = s1r;
      bus.issue_s1_val  = s1v;
      bus.issue_s1_tag  = s1t;
      bus.issue_s2_rdy  = s2r;
      bus.issue_s2_val  = s2v;
      bus.issue_s2_tag  = '0;
      bus.issue_dst_tag = dst;
      @(negedge clk);
      bus.issue_valid   = 1'b0;
   endtask

   // Scoreboard: every accepted broadcast must match the oldest expected result
   always begin
      @(negedge clk);
      #3;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_output", 64'(sb.size()), 64'd1);
         end else begin
            mon_e = sb.pop_front();
            check("sb_tag", 64'(bus.out_tag), 64'(mon_e.tag));
            check("sb_data", 64'(bus.out_data), 64'(mon_e.data));
            check("sb_flags", 64'(bus.out_flags), 64'(mon_e.flags));
         end
      end
   end

   initial begin
      bus.issue_valid = 1'b0;  bus.issue_aluc = '0;
      bus.issue_s1_rdy = 1'b0; bus.issue_s1_val = '0; bus.issue_s1_tag = '0;
      bus.issue_s2_rdy = 1'b0; bus.issue_s2_val = '0; bus.issue_s2_tag = '0;
      bus.issue_dst_tag = '0;  bus.cdb_valid = 1'b0;  bus.cdb_tag = '0;
      bus.cdb_data = '0;       bus.out_ready = 1'b1;

      #2;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
      check("rst_alu_aluc", 64'(bus.alu_aluc), 64'd0);
      check("rst_alu_src1", 64'(bus.alu_src1), 64'd0);
      check("rst_alu_src2", 64'(bus.alu_src2), 64'd0);
      check("rst_out_tag", 64'(bus.out_tag), 64'd0);
      check("rst_out_data", 64'(bus.out_data), 64'd0);
      check("rst_out_flags", 64'(bus.out_flags), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Ready ADDU: result visible two edges after issue
      issue_op(ALU_ADDU, 1'b1, 32'd5, '0, 1'b1, 32'd7, 4'd3);
      sb.push_back('{tag: 4'd3, data: 32'd12, flags: fexp(4'b0000)});
      check("lat_e0_out_valid", 64'(bus.out_valid), 64'd0);
      check("drive_aluc", 64'(bus.alu_aluc), 64'(ALU_ADDU));
      check("drive_src1", 64'(bus.alu_src1), 64'd5);
      check("drive_src2", 64'(bus.alu_src2), 64'd7);
      @(negedge clk);
      check("lat_e1_out_valid", 64'(bus.out_valid), 64'd1);
      check("lat_e1_out_tag", 64'(bus.out_tag), 64'd3);

      // SUB waiting on tag 6
      issue_op(ALU_SUB, 1'b0, 32'd0, 4'd6, 1'b1, 32'd1, 4'd5);
      sb.push_back('{tag: 4'd5, data: 32'd9, flags: fexp(4'b0000)});
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("wait_no_dispatch", 64'(bus.out_valid), 64'd0);
         check("wait_alu_idle", 64'({bus.alu_aluc, bus.alu_src2}), 64'd0);
      end
      bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd6; bus.cdb_data = 32'd10;
      @(negedge clk);
      bus.cdb_valid = 1'b0;
      check("wake_not_same_cycle", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      check("wake_out_valid", 64'(bus.out_valid), 64'd1);
      check("wake_out_data", 64'(bus.out_data), 64'd9);

      // Source captured from the CDB on the issue edge itself
      bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd2; bus.cdb_data = 32'h10;
      issue_op(ALU_OR, 1'b0, 32'd0, 4'd2, 1'b1, 32'h01, 4'd7);
      bus.cdb_valid = 1'b0;
      sb.push_back('{tag: 4'd7, data: 32'h11, flags: fexp(4'b0000)});
      @(negedge clk);
      check("cap_out_valid", 64'(bus.out_valid), 64'd1);
      check("cap_out_data", 64'(bus.out_data), 64'h11);
      @(negedge clk);

      // Back-pressure: five ready ops with the output blocked
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_issue_ready_hi", 64'(bus.issue_ready), 64'd1);
         issue_op(ALU_ADDU, 1'b1, 32'(i), '0, 1'b1, 32'h100, 4'(8 + i));
         ops4[i] = '{tag: 4'(8 + i), data: 32'(32'h100 + i), flags: fexp(4'b0000)};
      end
      check("bp_issue_ready_lo", 64'(bus.issue_ready), 64'd0);
      // op0 went straight to the output; op2 reused slot 0, so slot order is op2, op1, op3, op4
      sb.push_back(ops4[0]);
      sb.push_back(ops4[2]);
      sb.push_back(ops4[1]);
      sb.push_back(ops4[3]);
      sb.push_back(ops4[4]);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
         check("bp_hold_tag", 64'(bus.out_tag), 64'd8);
         check("bp_hold_data", 64'(bus.out_data), 64'h100);
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_stream_valid", 64'(bus.out_valid), 64'd1);
      end
      @(negedge clk);
      check("bp_stream_done", 64'(bus.out_valid), 64'd0);

      // Flush with three busy entries and a held output
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         issue_op(ALU_XOR, 1'b1, 32'(i), '0, 1'b1, 32'hFF, 4'(1 + i));
      end
      check("fl_pre_valid", 64'(bus.out_valid), 64'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("fl_out_valid", 64'(bus.out_valid), 64'd0);
      check("fl_issue_ready", 64'(bus.issue_ready), 64'd1);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("fl_no_output", 64'(bus.out_valid), 64'd0);
      end

      // SUBU 0-1: all-ones result, borrow and negative flags
      issue_op(ALU_SUBU, 1'b1, 32'd0, '0, 1'b1, 32'd1, 4'd9);
      sb.push_back('{tag: 4'd9, data: 32'hFFFF_FFFF, flags: fexp(4'b0110)});
      @(negedge clk);
      check("flag_out_data", 64'(bus.out_data), 64'hFFFF_FFFF);
      check("flag_out_flags", 64'(bus.out_flags), 64'(fexp(4'b0110)));
      @(negedge clk);

      // Asynchronous reset drops an in-flight output immediately
      bus.out_ready = 1'b0;
      issue_op(ALU_ADDU, 1'b1, 32'd1, '0, 1'b1, 32'd1, 4'd10);
      @(negedge clk);
      check("arst_pre_valid", 64'(bus.out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 64'(bus.out_valid), 64'd0);
      check("arst_out_data", 64'(bus.out_data), 64'd0);
      check("arst_issue_ready", 64'(bus.issue_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_rs.md
# alu_rs

Reservation station that sits in front of the combinational ALU in the dynamic pipeline. It accepts renamed ALU operations from the issue stage and holds them until both operands are available, snooping the common data bus (CDB) for missing values. It dispatches one ready operation per cycle to the ALU through its `alu_*` ports, then registers the ALU result, tagged with the destination, for broadcast through a valid/ready handshake to the CDB arbiter.

## Interface
- `DEPTH`, 4: number of station entries (2..8).
- `TAG_W`, 4: width of a rename tag.
- `clk` input 1: clock, all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous kill of all entries and of the output register.
- `issue_valid` input 1, `issue_ready` output 1: issue handshake.
- `issue_aluc` input 4: ALU opcode, using the shared encoding.
- `issue_s1_rdy` / `issue_s2_rdy` input 1: the source value is present; otherwise wait on the tag.
- `issue_s1_val` / `issue_s2_val` input 32: source values.
- `issue_s1_tag` / `issue_s2_tag` input TAG_W: producer tags.
- `issue_dst_tag` input TAG_W: destination tag.
- `cdb_valid` input 1, `cdb_tag` input TAG_W, `cdb_data` input 32: wakeup bus.
- `alu_aluc` output 4, `alu_src1` / `alu_src2` output 32: combinational drive to the ALU.
- `alu_result` input 32, `alu_zr` / `alu_cy` / `alu_ng` / `alu_of` input 1: ALU outputs.
- `out_valid` output 1, `out_ready` input 1: broadcast handshake.
- `out_tag` output TAG_W, `out_data` output 32, `out_flags` output 4 ({zr,cy,ng,of}).

## Operation
- **Entry state:** busy, aluc, and for each source a ready bit, value and tag; plus dst tag.
- **Issue:**
  - `issue_ready` = any entry not busy, computed from registered occupancy only.
  - A slot freed by a dispatch on the same edge is not reusable until the next cycle.
  - On handshake, the lowest-index free entry is allocated.
- **Issue-time capture:** if a source arrives not ready and `cdb_valid` with `cdb_tag` equal to its tag on the same edge, the entry stores `cdb_data` and marks that source ready. This is mandatory, because missing it deadlocks the op.
- **Wakeup:** each busy entry waiting on tag X captures `cdb_data` when `cdb_valid && cdb_tag==X`. Both sources may wake on the same edge.
- **Select:** the lowest-index busy entry with both sources ready. An entry is selected only if the output register is empty or draining (`!out_valid || out_ready`).
- **ALU drive:**
  - `alu_*` carry the selected entry's aluc/src1/src2.
  - All-zero when nothing is selected.
  - src1 is the shift-amount operand and src2 the shifted/LUI operand, per the shared encoding.
- **Dispatch edge:** `alu_result`, the flags and the dst tag load into the output register; `out_valid` is set and the entry's busy bit is cleared.
- **Drain:**
  - `out_valid && out_ready` clears `out_valid` unless a new dispatch reloads it on the same edge.
  - Held outputs stay stable while `out_valid && !out_ready`.
- **Flush:**
  - Clears all busy bits and `out_valid` on the edge.
  - Overrides issue, wakeup and dispatch on that edge.
  - `issue_ready` is high the next cycle.
- **Reset:** all busy bits cleared. `out_valid`, `out_tag`, `out_data` and `out_flags` are 0, `issue_ready` is 1, and `alu_*` are 0.

## Timing
- **Latency:** issue with both sources ready at edge E0 → dispatch at E1 → `out_valid` high from E1 until drained. That is 2 edges from issue to visible result.
- **Wakeup-to-dispatch:** a CDB wakeup at edge E makes the entry eligible for selection in the cycle after E, with dispatch at E+1. There is no same-cycle wakeup-and-dispatch.
- **Throughput:** one dispatch per cycle while `out_ready` stays high.
- **Back-pressure:** with `out_ready` low and the output full, no dispatch occurs. Entries keep waking up; when DEPTH entries are busy, `issue_ready` drops.
- **`rst_n` low mid-operation:** all state clears immediately (asynchronous). An in-flight output is lost.

## Configuration
- `ALU_RS_FLAGS_EN`:
  - Defined: the ALU flags are registered with the result and driven on `out_flags`.
  - Undefined: no flag storage, and `out_flags` is tied to 4'b0000.
  - Data path and timing are identical either way.

## Structure
- **Shared package:**
  - ALU opcode constants (ADDU 0000, SUBU 0001, ADD 0010, SUB 0011, AND 0100, OR 0101, XOR 0110, NOR 0111, LUI 1000, SLTU 1010, SLT 1011, SRA 1100, SRL 1101, SLL 1110).
  - Flag bit positions within `out_flags`.
  - Default DEPTH and TAG_W.
- **Sub-module:** one natural sub-module, `rs_entry` (storage, issue-time capture and CDB wakeup for a single slot), instantiated DEPTH times. Select and output register stay in the top.

## Test plan
- **Ready issue, ADDU:** issue ADDU src1=5, src2=7 both ready, dst=3 → 2 edges later `out_valid`=1, `out_tag`=3, `out_data`=12 (ALU model attached).
- **Single wakeup:** issue SUB with src1 waiting on tag 6 and src2=1 → no dispatch. Then CDB tag 6 data 10 → `out_data`=9 exactly two edges after the CDB edge.
- **Issue-time capture:** `issue_s1_rdy`=0, tag 2 while `cdb_valid`, `cdb_tag`=2, `cdb_data`=0x10 on the issue edge; src2=0x01 ready, op OR → `out_data`=0x11.
- **Back-pressure to full:** hold `out_ready`=0 and issue 5 ready ops with DEPTH=4 → one output held; `issue_ready` drops after the 5th op is accepted. Raise `out_ready` → the remaining four results emerge on consecutive cycles, lowest slot first.
- **Flush with pending work:** 3 busy entries and `out_valid`=1, assert `flush` → next cycle `out_valid`=0, `issue_ready`=1, and no further outputs appear.
- **Flag feature:** with `ALU_RS_FLAGS_EN`, SUBU 0-1 → `out_data`=0xFFFFFFFF and `out_flags` ng=1, cy=1. Without the macro → `out_flags`=0.
